// File: rtl/dp_fifo_ctrl.sv
// dp_fifo_ctrl: valid/ready FIFO controller for a dual-port synchronous RAM.
// Port A writes, port B reads. A 2-entry skid buffer on the output hides the
// RAM's one-cycle read latency so the FIFO can stream one word per cycle.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high in that cycle. valid never waits for ready, and wr_ready depends
// only on registered state (no combinational path from wr_valid or rd_ready).
module dp_fifo_ctrl #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [ADDRESS_WIDTH+1:0] level,
    output logic                     mem_ce_a,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_a,
    output logic [DATA_WIDTH-1:0]    mem_datain,
    output logic                     mem_ce_b,
    output logic                     mem_re,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_b,
    input  logic [DATA_WIDTH-1:0]    mem_dataout
);

    // Memory occupancy value meaning "every RAM location holds a live word".
    localparam logic [ADDRESS_WIDTH:0] C_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [ADDRESS_WIDTH:0]   r_mem_count;
    logic                     r_inflight;
    logic [1:0]               r_buf_cnt;
    logic [DATA_WIDTH-1:0]    r_buf0;      // head of the skid buffer
    logic [DATA_WIDTH-1:0]    r_buf1;      // tail when two words are held

    logic                     w_wr_fire;
    logic                     w_pop;
    logic [1:0]               w_occ;
    logic                     w_rd_issue;

    // Handshake and read-issue decisions; clr suppresses all memory traffic.
    always_comb begin
        w_wr_fire  = wr_valid && wr_ready && !clr;
        w_pop      = (r_buf_cnt != 2'd0) && rd_ready;
        // Words already owed to the output stage: buffered plus returning.
        w_occ      = r_buf_cnt + {1'b0, r_inflight};
        // Only issue when, after this cycle's pop, the buffer has a free
        // slot for the word that returns next cycle.
        w_rd_issue = (r_mem_count != '0) && (w_occ < (2'd2 + {1'b0, w_pop})) && !clr;
    end

    assign wr_ready   = (r_mem_count != C_FULL);
    assign rd_valid   = (r_buf_cnt != 2'd0);
    assign rd_data    = r_buf0;
    assign level      = {1'b0, r_mem_count}
                      + {{(ADDRESS_WIDTH+1){1'b0}}, r_inflight}
                      + {{ADDRESS_WIDTH{1'b0}}, r_buf_cnt};

    assign mem_ce_a   = w_wr_fire;
    assign mem_we     = w_wr_fire;
    assign mem_addr_a = r_wr_ptr;
    assign mem_datain = wr_data;
    assign mem_ce_b   = w_rd_issue;
    assign mem_re     = w_rd_issue;
    assign mem_addr_b = r_rd_ptr;

    // Pointers and memory occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_inflight  <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_inflight  <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_mem_count <= r_mem_count
                         + {{ADDRESS_WIDTH{1'b0}}, w_wr_fire}
                         - {{ADDRESS_WIDTH{1'b0}}, w_rd_issue};
            r_inflight  <= w_rd_issue;
        end
    end

    // Skid buffer: capture returning RAM data at the tail, shift out on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_cnt <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else if (clr) begin
            r_buf_cnt <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_buf0 <= mem_dataout;
                    end else begin
                        r_buf1 <= mem_dataout;
                    end
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0    <= r_buf1;
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the returning word lands behind
                    // whatever remains after the head leaves.
                    if (r_buf_cnt == 2'd1) begin
                        r_buf0 <= mem_dataout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= mem_dataout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_fifo_ctrl.sv
// Bench for dp_fifo_ctrl with a behavioural dual-port RAM and a queue model.
module tb_dp_fifo_ctrl;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] level;
    logic          mem_ce_a, mem_we, mem_ce_b, mem_re;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] mem_datain;
    logic [DW-1:0] mem_dataout = '0;

    logic [DW-1:0] mem_arr [0:DEPTH-1];

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q[$];

    // Values sampled on the falling edge by tick().
    logic          s_wr_ready, s_rd_valid, s_mem_we, s_mem_ce_b;
    logic          s_push, s_pop, s_exp_ok;
    logic [DW-1:0] s_rd_data, s_exp;
    logic [AW+1:0] s_level;
    int            s_exp_level;

    dp_fifo_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level),
        .mem_ce_a(mem_ce_a), .mem_we(mem_we), .mem_addr_a(mem_addr_a),
        .mem_datain(mem_datain),
        .mem_ce_b(mem_ce_b), .mem_re(mem_re), .mem_addr_b(mem_addr_b),
        .mem_dataout(mem_dataout)
    );

    // Clock and reset-independent RAM with one-cycle synchronous read.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce_a && mem_we) mem_arr[mem_addr_a] <= mem_datain;
        if (mem_ce_b && mem_re) mem_dataout <= mem_arr[mem_addr_b];
    end

    // One clock cycle: sample mid-cycle, advance the queue model with the
    // handshakes that will complete on the coming edge, then step past it.
    task automatic tick();
        @(negedge clk);
        s_wr_ready  = wr_ready;
        s_rd_valid  = rd_valid;
        s_rd_data   = rd_data;
        s_level     = level;
        s_mem_we    = mem_we;
        s_mem_ce_b  = mem_ce_b;
        s_exp_level = exp_q.size();
        s_push = 1'b0; s_pop = 1'b0; s_exp_ok = 1'b0; s_exp = '0;
        if (clr) begin
            exp_q.delete();
        end else begin
            s_pop  = rd_valid && rd_ready;
            s_push = wr_valid && wr_ready;
            if (s_pop && exp_q.size() != 0) begin
                s_exp    = exp_q.pop_front();
                s_exp_ok = 1'b1;
            end
            if (s_push) exp_q.push_back(wr_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset rd_valid: got %b expected 0", rd_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset wr_ready: got %b expected 1", wr_ready); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset level: got %0d expected 0", level); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset rd_data: got %h expected 0", rd_data); end
        checks++; if ({mem_ce_a, mem_we, mem_ce_b, mem_re} !== 4'b0) begin
            errors++; $display("FAIL reset mem enables: got %b expected 0000", {mem_ce_a, mem_we, mem_ce_b, mem_re});
        end
    endtask

    task automatic test_back_to_back();
        int n_sent = 0, n_got = 0, first_push = -1, first_valid = -1;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 30 && n_got < 4; cyc++) begin
            wr_valid = (n_sent < 4);
            wr_data  = DW'(n_sent + 1);
            tick();
            if (s_push && first_push < 0) first_push = cyc;
            if (s_rd_valid && first_valid < 0) first_valid = cyc;
            if (s_push) n_sent++;
            checks++; if (s_level !== (AW+2)'(s_exp_level)) begin errors++; $display("FAIL b2b level: got %0d expected %0d", s_level, s_exp_level); end
            if (s_pop) begin
                n_got++;
                checks++; if (!s_exp_ok || s_rd_data !== s_exp) begin errors++; $display("FAIL b2b data: got %h expected %h", s_rd_data, s_exp); end
            end
        end
        wr_valid = 1'b0;
        checks++; if (n_got != 4) begin errors++; $display("FAIL b2b count: got %0d expected 4", n_got); end
        checks++; if (first_valid - first_push != 3) begin errors++; $display("FAIL b2b latency: got %0d expected 3", first_valid - first_push); end
        tick();
        checks++; if (s_level !== '0) begin errors++; $display("FAIL b2b final level: got %0d expected 0", s_level); end
    endtask

    task automatic test_fill();
        int n_sent = 0;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int cyc = 0; cyc < 8400 && n_sent < DEPTH + 2; cyc++) begin
            wr_data = DW'(n_sent);
            tick();
            if (s_exp_level < DEPTH) begin
                checks++; if (s_wr_ready !== 1'b1) begin errors++; $display("FAIL fill wr_ready early: got 0 expected 1 at level %0d", s_exp_level); end
            end
            if (s_push) n_sent++;
        end
        checks++; if (n_sent != DEPTH + 2) begin errors++; $display("FAIL fill accepted: got %0d expected %0d", n_sent, DEPTH + 2); end
        wr_data = 32'hBAD0BAD0;
        tick();
        checks++; if (s_wr_ready !== 1'b0) begin errors++; $display("FAIL fill wr_ready full: got %b expected 0", s_wr_ready); end
        checks++; if (s_level !== (AW+2)'(DEPTH + 2)) begin errors++; $display("FAIL fill level: got %0d expected %0d", s_level, DEPTH + 2); end
        wr_valid = 1'b0;
    endtask

    task automatic test_full_simul();
        wr_valid = 1'b1;
        wr_data  = 32'hF00D0001;
        rd_ready = 1'b1;
        tick();
        checks++; if (s_wr_ready !== 1'b0) begin errors++; $display("FAIL full_simul first cycle wr_ready: got %b expected 0", s_wr_ready); end
        checks++; if (!s_pop || !s_exp_ok || s_rd_data !== s_exp) begin errors++; $display("FAIL full_simul pop data: got %h expected %h", s_rd_data, s_exp); end
        rd_ready = 1'b0;
        tick();
        checks++; if (s_push !== 1'b1) begin errors++; $display("FAIL full_simul next cycle write: got %b expected 1", s_push); end
        wr_valid = 1'b0;
    endtask

    task automatic test_drain(input int expect_words);
        int n_got = 0;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < expect_words + 50 && exp_q.size() != 0; cyc++) begin
            tick();
            if (s_pop) begin
                n_got++;
                checks++; if (!s_exp_ok || s_rd_data !== s_exp) begin errors++; $display("FAIL drain data: got %h expected %h", s_rd_data, s_exp); end
            end
        end
        checks++; if (n_got != expect_words) begin errors++; $display("FAIL drain count: got %0d expected %0d", n_got, expect_words); end
        tick();
        checks++; if (s_level !== '0 || s_rd_valid !== 1'b0) begin errors++; $display("FAIL drain empty: got level %0d valid %b expected 0 0", s_level, s_rd_valid); end
    endtask

    task automatic test_wrap();
        int n_sent = 0, n_got = 0;
        for (int cyc = 0; cyc < 40000 && n_got < 20000; cyc++) begin
            wr_valid = (n_sent < 20000);
            wr_data  = 32'h1000_0000 + DW'(n_sent);
            rd_ready = ((cyc % 4) != 1);
            tick();
            if (s_push) n_sent++;
            if (s_exp_level < DEPTH) begin
                checks++; if (s_wr_ready !== 1'b1) begin errors++; $display("FAIL wrap wr_ready: got 0 expected 1 at level %0d", s_exp_level); end
            end
            if (s_pop) begin
                n_got++;
                checks++; if (!s_exp_ok || s_rd_data !== s_exp) begin errors++; $display("FAIL wrap data: got %h expected %h", s_rd_data, s_exp); end
            end
        end
        wr_valid = 1'b0;
        checks++; if (n_got != 20000) begin errors++; $display("FAIL wrap count: got %0d expected 20000", n_got); end
        tick();
        checks++; if (s_level !== '0) begin errors++; $display("FAIL wrap final level: got %0d expected 0", s_level); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            rd_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (s_level !== (AW+2)'(s_exp_level)) begin errors++; $display("FAIL random level: got %0d expected %0d", s_level, s_exp_level); end
            if (s_exp_level == 0) begin
                checks++; if (s_rd_valid !== 1'b0) begin errors++; $display("FAIL random rd_valid when empty: got 1 expected 0"); end
            end
            if (s_pop) begin
                checks++; if (!s_exp_ok || s_rd_data !== s_exp) begin errors++; $display("FAIL random data: got %h expected %h", s_rd_data, s_exp); end
            end
        end
        wr_valid = 1'b0;
        test_drain(exp_q.size());
    endtask

    task automatic test_clr();
        int n_sent = 0, n_got = 0;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && n_sent < 5; cyc++) begin
            wr_data = 32'hC0 + DW'(n_sent);
            tick();
            if (s_push) n_sent++;
        end
        wr_valid = 1'b0;
        repeat (4) tick();
        checks++; if (s_level !== (AW+2)'(5)) begin errors++; $display("FAIL clr pre level: got %0d expected 5", s_level); end
        // One pop plus one write: the pop frees a buffer slot so a read issues.
        rd_ready = 1'b1; wr_valid = 1'b1; wr_data = 32'hC5;
        tick();
        checks++; if (s_mem_ce_b !== 1'b1) begin errors++; $display("FAIL clr read issue: got %b expected 1", s_mem_ce_b); end
        checks++; if (!s_pop || !s_exp_ok || s_rd_data !== s_exp) begin errors++; $display("FAIL clr pop data: got %h expected %h", s_rd_data, s_exp); end
        clr = 1'b1; rd_ready = 1'b0; wr_valid = 1'b1; wr_data = 32'hDEADDEAD;
        tick();
        checks++; if (s_level !== (AW+2)'(5)) begin errors++; $display("FAIL clr cycle level: got %0d expected 5", s_level); end
        checks++; if (s_mem_we !== 1'b0) begin errors++; $display("FAIL clr write dropped: got mem_we %b expected 0", s_mem_we); end
        clr = 1'b0; wr_valid = 1'b0;
        tick();
        checks++; if (s_level !== '0 || s_rd_valid !== 1'b0) begin errors++; $display("FAIL clr after: got level %0d valid %b expected 0 0", s_level, s_rd_valid); end
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            wr_valid = (cyc < 2);
            wr_data  = (cyc == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
            tick();
            if (s_pop) begin
                n_got++;
                checks++; if (!s_exp_ok || s_rd_data !== s_exp) begin errors++; $display("FAIL clr readback: got %h expected %h", s_rd_data, s_exp); end
            end
        end
        checks++; if (n_got != 2) begin errors++; $display("FAIL clr readback count: got %0d expected 2", n_got); end
    endtask

    task automatic test_async_reset();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_data = $urandom;
            tick();
        end
        wr_valid = 1'b0;
        repeat (4) tick();
        checks++; if (s_level !== (AW+2)'(100)) begin errors++; $display("FAIL areset pre level: got %0d expected 100", s_level); end
        // A pop this cycle issues a read, so mem_ce_b is high before reset.
        rd_ready = 1'b1;
        #2;
        checks++; if (mem_ce_b !== 1'b1) begin errors++; $display("FAIL areset pre read enable: got %b expected 1", mem_ce_b); end
        rst_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0 || level !== '0) begin errors++; $display("FAIL areset immediate: got valid %b level %0d expected 0 0", rd_valid, level); end
        checks++; if ({mem_ce_a, mem_we, mem_ce_b, mem_re} !== 4'b0) begin errors++; $display("FAIL areset enables: got %b expected 0000", {mem_ce_a, mem_we, mem_ce_b, mem_re}); end
        exp_q.delete();
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (wr_ready !== 1'b1 || level !== '0) begin errors++; $display("FAIL areset release: got ready %b level %0d expected 1 0", wr_ready, level); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        test_back_to_back();
        test_fill();
        test_full_simul();
        test_drain(DEPTH + 2);
        test_wrap();
        test_random();
        test_clr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dp_fifo_ctrl.md
Name: dp_fifo_ctrl

Overview:
- Valid/ready FIFO controller that sits directly upstream of the dual-port memory (dp_memory_8192x32 / dp_memory_generic) and drives its port A (write) and port B (read).
- Generates write and read pointers and tracks occupancy.
- Hides the memory's 1-cycle synchronous read latency behind a 2-entry output skid buffer, giving full-throughput streaming.
- Used wherever a 32-bit-wide, 8K-deep elastic buffer is needed.

Parameters:
- ADDRESS_WIDTH, 13, memory address width; memory depth DEPTH = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, data word width.

Ports:
- clk  input  1  single clock for all logic and the memory.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous flush; empties the FIFO.
- wr_valid  input  1  producer has a word.
- wr_ready  output  1  FIFO can accept a word.
- wr_data  input  DATA_WIDTH  write word.
- rd_valid  output  1  rd_data holds a valid word.
- rd_ready  input  1  consumer accepts rd_data.
- rd_data  output  DATA_WIDTH  head-of-FIFO word.
- level  output  ADDRESS_WIDTH+2  total words held (memory + in-flight + buffer).
- mem_ce_a  output  1  memory port A chip enable.
- mem_we  output  1  memory write enable.
- mem_addr_a  output  ADDRESS_WIDTH  write address.
- mem_datain  output  DATA_WIDTH  write data.
- mem_ce_b  output  1  memory port B chip enable.
- mem_re  output  1  memory read enable.
- mem_addr_b  output  ADDRESS_WIDTH  read address.
- mem_dataout  input  DATA_WIDTH  read data, valid the cycle after mem_ce_b & mem_re.

Behaviour:
- Reset (rst_n low, async):
  - wr_ptr, rd_ptr, mem_count, in-flight flag and buffer count all cleared.
  - rd_valid=0, wr_ready=1, level=0; all mem_* enables 0.
  - rd_data is 0 and holds 0 until the first buffered word.
- Internal state:
  - mem_count, 0..DEPTH, width ADDRESS_WIDTH+1: words written but not yet read out of the memory.
  - inflight, 0/1: a memory read was issued last cycle.
  - buf_cnt, 0..2: skid buffer occupancy.
- Write:
  - wr_ready = (mem_count != DEPTH), driven from registered state only. A same-cycle read does not free a slot that cycle.
  - wr_fire = wr_valid & wr_ready.
  - On wr_fire: mem_ce_a = mem_we = 1, mem_addr_a = wr_ptr, mem_datain = wr_data (combinational pass-through).
  - wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read issue:
  - rd_issue = (mem_count != 0) & (buf_cnt + inflight - pop < 2), where pop = rd_valid & rd_ready.
  - On rd_issue: mem_ce_b = mem_re = 1, mem_addr_b = rd_ptr. rd_ptr increments with wrap and mem_count decrements.
  - mem_count next = mem_count + wr_fire - rd_issue.
- Read-after-write hazard:
  - A word written in cycle N is counted from N+1, so its read is issued at N+1 at the earliest.
  - Port A and port B are never at the same address in the same cycle for live data.
- Data return:
  - When inflight=1, mem_dataout is captured into the skid buffer tail.
- Output:
  - rd_valid = (buf_cnt != 0); rd_data = buffer head (registered).
  - On pop, the head shifts out. Simultaneous capture and pop is legal and keeps order.
- Latency and throughput:
  - First-word latency: write accepted at cycle N -> rd_valid high at N+3.
  - Steady-state throughput is 1 word/cycle in and out when rd_ready is held high.
- Level: level = mem_count + inflight + buf_cnt; maximum DEPTH+2.
- clr (synchronous, higher priority than any same-cycle wr/rd):
  - All state returns to reset values next cycle.
  - The in-flight read return is discarded, and the wr_fire in the clr cycle is dropped.
  - Memory contents are not cleared.
- Backpressure:
  - rd_ready low while rd_valid=1 holds rd_data stable.
  - buf_cnt never exceeds 2, and no return data is lost.

Test Plan:
- Reset, then write 0x00000001..0x00000004 back-to-back with rd_ready=1 → rd_data reads 1,2,3,4 in order; first rd_valid 3 cycles after the first write; level returns to 0.
- Fill with rd_ready=0: write 8194 words (0..8193) → wr_ready falls after word 8193 is accepted (8192 in memory + 2 buffered); level=8194; then drain → all 8194 values read in order.
- Wrap-around: stream 20000 incrementing words with rd_ready toggling 1-0-1-1 → output sequence identical to input, no gaps, no duplicates.
- Full plus simultaneous read: at level=8194, assert wr_valid and rd_ready together → no write that cycle; write accepted the next cycle; data order preserved.
- clr mid-stream: with 5 words held and a read in flight, pulse clr together with wr_valid → next cycle level=0, rd_valid=0; the following writes 0xA5A5A5A5 and 0x5A5A5A5A read back exactly those two.
- Async reset mid-operation: drop rst_n between clock edges while level=100 → rd_valid=0, level=0 and mem enables 0 immediately, without waiting for a clock edge.
